// File: rtl/muldiv_if.sv
// muldiv_if: bus-side signals of the multi-cycle multiply/divide unit.
//
// Handshake: start is sampled only while the unit is idle (busy=0, done=0);
// the edge that samples it also captures op, A (from Y) and B (from bus).
// busy stays high through the iteration and fix-up cycles. done is a
// single-cycle pulse, with busy low, that marks zhi/zlo/div_by_zero as
// freshly written. A start raised at any other time is dropped, not queued.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] bus;
  logic             y_enable;
  logic             start;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] y_data;
  logic [WIDTH-1:0] zhi_data;
  logic [WIDTH-1:0] zlo_data;
  logic [1:0]       state_dbg;

  modport master (
    output bus, y_enable, start, op,
    input  busy, done, div_by_zero, y_data, zhi_data, zlo_data, state_dbg
  );

  modport slave (
    input  bus, y_enable, start, op,
    output busy, done, div_by_zero, y_data, zhi_data, zlo_data, state_dbg
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier and restoring divider.
// A operand comes from the Y register, B from the bus at start; the
// double-width result is written to ZHI/ZLO in the FIX cycle.
// Latency is WIDTH+2 cycles from the start edge to the falling edge of done.
// Optional feature macro: MULDIV_SIGNED_EN (op[0] selects signed operation;
// when undefined every op is unsigned and no sign logic exists).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    clr,
  muldiv_if.slave bus_if
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_inc;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_zhi;
  logic [WIDTH-1:0]   r_zlo;
  logic               r_dbz;
  // Multiply: r_acc holds {partial hi, multiplier}; r_opnd the multiplicand.
  // Divide: r_acc[WIDTH-1:0] shifts dividend out and quotient in;
  // r_opnd is the divisor and r_rem the partial remainder.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH:0]     r_rem;
  logic               r_is_div;
  logic               r_dbz_pend;
  logic               w_start_go;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_trial;
  logic               w_unused;

  assign w_start_go  = (r_state == S_IDLE) && bus_if.start;
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_div_shift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opnd};

`ifdef MULDIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg  = bus_if.op[0] & r_y[WIDTH-1];
  assign w_b_neg  = bus_if.op[0] & bus_if.bus[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -r_y : r_y;
  assign w_b_mag  = w_b_neg ? -bus_if.bus : bus_if.bus;
  // The top remainder bit is only a borrow during the trial subtract.
  assign w_unused = r_rem[WIDTH];

  // Record result signs at start: product/quotient negative when the
  // operand signs differ, remainder follows the dividend.
  always_ff @(posedge clk) begin
    if (w_start_go) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end

  // Sign correction of the magnitude result for the FIX write.
  always_comb begin
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_hi = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
      w_fix_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      if (r_dbz_pend) w_fix_lo = '1;
    end else if (r_neg_q) begin
      {w_fix_hi, w_fix_lo} = -r_acc;
    end
  end
`else
  assign w_a_mag  = r_y;
  assign w_b_mag  = bus_if.bus;
  // op[0] has no meaning without signed support; the top remainder bit is
  // only a borrow during the trial subtract.
  assign w_unused = r_rem[WIDTH] ^ bus_if.op[0];

  // Unsigned result selection for the FIX write.
  always_comb begin
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_hi = r_rem[WIDTH-1:0];
      w_fix_lo = r_dbz_pend ? '1 : r_acc[WIDTH-1:0];
    end
  end
`endif

  // Next-state logic: RUN lasts exactly WIDTH cycles, FIX and DONE one each.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus_if.start) w_state_next = S_RUN;
      S_RUN:   if (w_cnt_inc == CW'(WIDTH)) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register and iteration counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_go) r_cnt <= '0;
      else if (r_state == S_RUN) r_cnt <= w_cnt_inc;
    end
  end

  // Architectural registers: Y loads any time, Z and div_by_zero only in FIX.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_y   <= '0;
      r_zhi <= '0;
      r_zlo <= '0;
      r_dbz <= 1'b0;
    end else begin
      if (bus_if.y_enable) r_y <= bus_if.bus;
      if (r_state == S_FIX) begin
        r_zhi <= w_fix_hi;
        r_zlo <= w_fix_lo;
        r_dbz <= r_is_div & r_dbz_pend;
      end
    end
  end

  // Operand capture at start, then one shift-add or shift-subtract per RUN cycle.
  always_ff @(posedge clk) begin
    if (w_start_go) begin
      r_is_div   <= bus_if.op[1];
      r_dbz_pend <= bus_if.op[1] && (bus_if.bus == '0);
      r_rem      <= '0;
      if (bus_if.op[1]) begin
        r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
        r_opnd <= w_b_mag;
      end else begin
        r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
        r_opnd <= w_a_mag;
      end
    end else if (r_state == S_RUN) begin
      if (r_is_div) begin
        r_rem <= w_div_trial[WIDTH] ? w_div_shift : w_div_trial;
        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], ~w_div_trial[WIDTH]};
      end else begin
        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
      end
    end
  end

  assign bus_if.busy        = (r_state == S_RUN) || (r_state == S_FIX);
  assign bus_if.done        = (r_state == S_DONE);
  assign bus_if.div_by_zero = r_dbz;
  assign bus_if.y_data      = r_y;
  assign bus_if.zhi_data    = r_zhi;
  assign bus_if.zlo_data    = r_zlo;
  assign bus_if.state_dbg   = r_state;
endmodule
